// File: rtl/uart_out_queue.sv
// uart_out_queue
//   Buffered byte serialiser between the execute stage and uart_tx. The core
//   pushes a word plus a byte count; entries are queued in a small RAM and
//   sent one byte at a time through the tx_start / tx_busy handshake, so the
//   core only stalls when the queue is full.
//
// Optional build macro:
//   UART_OUT_QUEUE_FLUSH_EN - adds input 'flush', which empties the queue and
//                             aborts the word being serialised.
//
// Ports:
//   clk          system clock
//   rstn         synchronous active-low reset
//   flush        (UART_OUT_QUEUE_FLUSH_EN only) discard queue and current word
//   push_valid   core offers an entry
//   push_ready   queue can accept an entry (~full)
//   push_data    word to transmit
//   push_nbytes  number of low-order bytes to send (0 or too large = all)
//   tx_data      byte to uart_tx
//   tx_start     one-cycle start pulse to uart_tx
//   tx_busy      uart_tx busy
//   level        occupied entries, 0..DEPTH
//   empty        level == 0
//   idle         queue empty and serialiser idle
module uart_out_queue #(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 16,
   parameter int MSB_FIRST = 0
) (
   input  logic                        clk,
   input  logic                        rstn,
`ifdef UART_OUT_QUEUE_FLUSH_EN
   input  logic                        flush,
`endif
   input  logic                        push_valid,
   output logic                        push_ready,
   input  logic [DATA_W-1:0]           push_data,
   input  logic [$clog2(DATA_W/8):0]   push_nbytes,
   output logic [7:0]                  tx_data,
   output logic                        tx_start,
   input  logic                        tx_busy,
   output logic [$clog2(DEPTH):0]      level,
   output logic                        empty,
   output logic                        idle
);

   localparam int NB = DATA_W / 8;
   localparam int CW = $clog2(NB) + 1;
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int EW = CW + DATA_W;

   localparam logic [CW-1:0] NB_C = CW'(NB);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ARM   = 2'd1;
   localparam logic [1:0] S_GUARD = 2'd2;
   localparam logic [1:0] S_WAIT  = 2'd3;

   // Out-of-range byte counts mean "send the whole word".
   function automatic logic [CW-1:0] eff_nbytes(input logic [CW-1:0] n);
      if (n == '0 || n > NB_C) return NB_C;
      return n;
   endfunction

   // For MSB-first order, move the highest selected byte to the top of the
   // shift register so every step is a plain shift left by 8.
   function automatic logic [DATA_W-1:0] align_word(input logic [DATA_W-1:0] d,
                                                    input logic [CW-1:0]     n);
      if (MSB_FIRST != 0) return d << (8 * (NB - int'(n)));
      return d;
   endfunction

   function automatic logic [7:0] cur_byte(input logic [DATA_W-1:0] s);
      if (MSB_FIRST != 0) return s[DATA_W-1 -: 8];
      return s[7:0];
   endfunction

   function automatic logic [DATA_W-1:0] next_word(input logic [DATA_W-1:0] s);
      if (MSB_FIRST != 0) return s << 8;
      return s >> 8;
   endfunction

   logic [EW-1:0]     mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [1:0]        state;
   logic [DATA_W-1:0] sh;
   logic [CW-1:0]     cnt;

   logic              flush_req;
   logic              full;
   logic              do_push;
   logic              do_pop;
   logic [EW-1:0]     head;
   logic [CW-1:0]     head_n;
   logic [DATA_W-1:0] head_d;

`ifdef UART_OUT_QUEUE_FLUSH_EN
   assign flush_req = flush;
`else
   assign flush_req = 1'b0;
`endif

   assign full       = (level == LW'(DEPTH));
   assign push_ready = ~full;
   assign empty      = (level == '0);
   assign idle       = empty && (state == S_IDLE);

   // Flush wins over a simultaneous push and suppresses the pop.
   assign do_push = push_valid && push_ready && !flush_req;
   assign do_pop  = (state == S_IDLE) && !empty && !flush_req;

   assign head   = mem[rd_ptr];
   assign head_n = head[EW-1 -: CW];
   assign head_d = head[DATA_W-1:0];

   // Storage: no reset on RAM contents.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= {eff_nbytes(push_nbytes), push_data};
   end

   // Serialiser data path: shift register and byte counter.
   always_ff @(posedge clk) begin
      if (do_pop) begin
         sh  <= align_word(head_d, head_n);
         cnt <= head_n;
      end else if (state == S_WAIT && !tx_busy) begin
         sh  <= next_word(sh);
         cnt <= cnt - CW'(1);
      end
   end

   // Queue pointers, level and serialiser FSM.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         state    <= S_IDLE;
         tx_start <= 1'b0;
         tx_data  <= '0;
      end else if (flush_req) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         state    <= S_IDLE;
         tx_start <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase

         case (state)
            S_IDLE: begin
               if (do_pop) state <= S_ARM;
            end
            S_ARM: begin
               if (!tx_busy) begin
                  tx_data  <= cur_byte(sh);
                  tx_start <= 1'b1;
                  state    <= S_GUARD;
               end
            end
            // uart_tx raises busy one cycle after tx_start; skip that cycle.
            S_GUARD: begin
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (!tx_busy) state <= (cnt == CW'(1)) ? S_IDLE : S_ARM;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
